// File: rtl/reduce_pkg.sv
// Shared op encodings and helpers for the pipelined bitwise reduction tree.
package reduce_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  // Widest operand the combine helper handles; callers cast in and out of this width.
  localparam int unsigned MaxW = 64;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

  // NAND combines as AND here; inversion is applied once, at the final stage.
  function automatic logic [MaxW-1:0] combine(input logic [1:0] op,
                                              input logic [MaxW-1:0] x,
                                              input logic [MaxW-1:0] y);
    logic [MaxW-1:0] r;
    case (op)
      OP_OR:   r = x | y;
      OP_XOR:  r = x ^ y;
      default: r = x & y;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/reduce_stage.sv
// One level of the reduction tree: M words in, M/2 registered words out, global hold.
module reduce_stage
  import reduce_pkg::*;
#(
  parameter int unsigned M          = 2,
  parameter int unsigned W          = 1,
  parameter bit          InvertNand = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 hold,
  input  logic                 in_valid,
  input  logic [1:0]           in_op,
  input  logic [M*W-1:0]       in_data,
  output logic                 out_valid,
  output logic [1:0]           out_op,
  output logic [(M/2)*W-1:0]   out_data
);

  localparam int unsigned P = M / 2;

  logic [P*W-1:0] data_d, data_q;
  logic [1:0]     op_q;
  logic           valid_q;

  always_comb begin
    data_d = '0;
    for (int unsigned i = 0; i < P; i++) begin
      data_d[i*W +: W] = W'(combine(in_op, MaxW'(in_data[2*i*W +: W]),
                                    MaxW'(in_data[(2*i+1)*W +: W])));
    end
    if (InvertNand && (in_op == OP_NAND)) data_d = ~data_d;
  end

  // Data and op only load on valid so the output keeps its last computed value across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      op_q    <= '0;
      data_q  <= '0;
    end else if (!hold) begin
      valid_q <= in_valid;
      if (in_valid) begin
        op_q   <= in_op;
        data_q <= data_d;
      end
    end
  end

  assign out_valid = valid_q;
  assign out_op    = op_q;
  assign out_data  = data_q;

endmodule

// File: rtl/reduce_tree_pipe.sv
// Pipelined N-operand AND/OR/XOR/NAND reduction with valid/ready flow control and a global stall.
module reduce_tree_pipe
  import reduce_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned W = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] a,
  input  logic [1:0]     op,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out,
  output logic [1:0]     out_op
);

  localparam int unsigned L = clog2(N);

  if ((N < 2) || ((N & (N - 1)) != 0)) begin : g_bad_n
    $error("reduce_tree_pipe: N must be a power of two >= 2");
  end
  if ((W < 1) || (W > MaxW)) begin : g_bad_w
    $error("reduce_tree_pipe: W out of range");
  end

  logic stall;

  for (genvar k = 0; k < L; k++) begin : g_stage
    localparam int unsigned M = N >> k;

    logic                 v_in;
    logic [1:0]           op_in;
    logic [M*W-1:0]       d_in;
    logic                 v_out;
    logic [1:0]           op_out;
    logic [(M/2)*W-1:0]   d_out;

    if (k == 0) begin : g_first
      assign v_in  = in_valid;
      assign op_in = op;
      assign d_in  = a;
    end else begin : g_next
      assign v_in  = g_stage[k-1].v_out;
      assign op_in = g_stage[k-1].op_out;
      assign d_in  = g_stage[k-1].d_out;
    end

    reduce_stage #(
      .M          (M),
      .W          (W),
      .InvertNand (k == L - 1)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .hold      (stall),
      .in_valid  (v_in),
      .in_op     (op_in),
      .in_data   (d_in),
      .out_valid (v_out),
      .out_op    (op_out),
      .out_data  (d_out)
    );
  end

  assign out_valid = g_stage[L-1].v_out;
  assign out_op    = g_stage[L-1].op_out;
  assign out       = g_stage[L-1].d_out;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

endmodule

// File: tb/tb_reduce_tree_pipe.sv
// Directed and scoreboard bench for reduce_tree_pipe at N=8/W=4, N=2/W=1 and N=16/W=8.
module tb_reduce_tree_pipe;

  localparam logic [1:0] AND_OP  = 2'b00;
  localparam logic [1:0] OR_OP   = 2'b01;
  localparam logic [1:0] XOR_OP  = 2'b10;
  localparam logic [1:0] NAND_OP = 2'b11;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // N=8, W=4
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a;
  logic [1:0]  op, out_op;
  logic [3:0]  out;

  // N=2, W=1
  logic       d2_in_valid, d2_in_ready, d2_out_valid, d2_out_ready;
  logic [1:0] d2_a, d2_op, d2_out_op;
  logic [0:0] d2_out;

  // N=16, W=8
  logic         d16_in_valid, d16_in_ready, d16_out_valid, d16_out_ready;
  logic [127:0] d16_a;
  logic [1:0]   d16_op, d16_out_op;
  logic [7:0]   d16_out;

  reduce_tree_pipe #(.N(8), .W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .out_op(out_op)
  );

  reduce_tree_pipe #(.N(2), .W(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(d2_in_valid), .in_ready(d2_in_ready), .a(d2_a),
    .op(d2_op), .out_valid(d2_out_valid), .out_ready(d2_out_ready), .out(d2_out),
    .out_op(d2_out_op)
  );

  reduce_tree_pipe #(.N(16), .W(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(d16_in_valid), .in_ready(d16_in_ready), .a(d16_a),
    .op(d16_op), .out_valid(d16_out_valid), .out_ready(d16_out_ready), .out(d16_out),
    .out_op(d16_out_op)
  );

  // Reference: fold n words of w bits sequentially, invert at the end for NAND.
  function automatic logic [7:0] ref_reduce(input logic [127:0] v, input int n, input int w,
                                            input logic [1:0] o);
    logic [7:0] mask, r, word;
    mask = 8'((1 << w) - 1);
    r = 8'(v) & mask;
    for (int i = 1; i < n; i++) begin
      word = 8'(v >> (i * w)) & mask;
      if (o == OR_OP) r = r | word;
      else if (o == XOR_OP) r = r ^ word;
      else r = r & word;
    end
    if (o == NAND_OP) r = ~r & mask;
    return r;
  endfunction

  task automatic test_reset();
    in_valid = 0; a = '0; op = '0; out_ready = 1;
    d2_in_valid = 0; d2_a = '0; d2_op = '0; d2_out_ready = 1;
    d16_in_valid = 0; d16_a = '0; d16_op = '0; d16_out_ready = 1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out !== 4'h0 || out_op !== 2'b00) begin
      errors++;
      $display("FAIL reset_during: out_valid=%b out=%h out_op=%b, want 0/0/0",
               out_valid, out, out_op);
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || out !== 4'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_after: out_valid=%b out=%h in_ready=%b, want 0/0/1",
               out_valid, out, in_ready);
    end
  endtask

  task automatic test_idle();
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL idle cycle %0d: out_valid=%b in_ready=%b, want 0/1",
                 c, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_single();
    logic [31:0] va [3];
    logic [1:0]  vo [3];
    logic [3:0]  ve [3];
    va = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0010_0000};
    vo = '{AND_OP, NAND_OP, OR_OP};
    ve = '{4'hF, 4'h0, 4'h1};
    for (int t = 0; t < 3; t++) begin
      @(posedge clk); #1;
      in_valid = 1; a = va[t]; op = vo[t];
      @(posedge clk); #1;  // accepted at this edge (E)
      in_valid = 0;
      for (int c = 0; c < 4; c++) begin
        if (c > 0) begin @(posedge clk); #1; end
        checks++;
        if (out_valid !== (c == 2)) begin
          errors++;
          $display("FAIL single%0d valid after E+%0d: got %b want %b", t, c, out_valid, c == 2);
        end
        if (c == 2) begin
          checks++;
          if (out !== ve[t] || out_op !== vo[t]) begin
            errors++;
            $display("FAIL single%0d data: out=%h op=%b want %h/%b", t, out, out_op, ve[t], vo[t]);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] vo [4];
    logic [3:0] ve [4];
    int j;
    vo = '{AND_OP, OR_OP, XOR_OP, NAND_OP};
    ve = '{4'h0, 4'hF, 4'hA, 4'hF};
    @(posedge clk); #1;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      j = c - 3;
      checks++;
      if (out_valid !== (j >= 0 && j < 4)) begin
        errors++;
        $display("FAIL b2b valid iter %0d: got %b", c, out_valid);
      end else if (j >= 0 && j < 4) begin
        checks++;
        if (out !== ve[j] || out_op !== vo[j]) begin
          errors++;
          $display("FAIL b2b result %0d: out=%h op=%b want %h/%b", j, out, out_op, ve[j], vo[j]);
        end
      end
      in_valid = (c < 4);
      a = 32'h0000_F731;
      op = (c < 4) ? vo[c] : 2'b00;
    end
    in_valid = 0;
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int rcvd = 0;
    logic [3:0] held = '0;
    @(posedge clk); #1;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      out_ready = !(c >= 4 && c <= 6);
      in_valid = (sent < 6);
      a = {28'h0, 4'(sent + 1)};
      op = OR_OP;
      #1;
      if (!out_ready) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL bp stall iter %0d: in_ready=%b out_valid=%b want 0/1",
                   c, in_ready, out_valid);
        end
        if (c == 4) held = out;
        else begin
          checks++;
          if (out !== held) begin
            errors++;
            $display("FAIL bp hold iter %0d: out=%h want %h", c, out, held);
          end
        end
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        checks++;
        if (out !== 4'(rcvd + 1) || out_op !== OR_OP) begin
          errors++;
          $display("FAIL bp order %0d: out=%h op=%b want %h/%b", rcvd, out, out_op,
                   4'(rcvd + 1), OR_OP);
        end
        rcvd++;
      end
    end
    in_valid = 0;
    out_ready = 1;
    checks++;
    if (rcvd != 6 || sent != 6) begin
      errors++;
      $display("FAIL bp count: sent=%0d rcvd=%0d want 6/6", sent, rcvd);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; a = 32'hFFFF_FFFF; op = AND_OP;
      @(posedge clk); #1;
    end
    in_valid = 0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid precondition: out_valid=%b want 1", out_valid);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid immediate: out_valid=%b want 0", out_valid);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rstmid stale cycle %0d: out_valid=%b want 0", c, out_valid);
      end
    end
  endtask

  task automatic test_n2();
    logic [7:0] e;
    for (int o = 0; o < 4; o++) begin
      for (int v = 0; v < 4; v++) begin
        @(posedge clk); #1;
        d2_in_valid = 1; d2_a = 2'(v); d2_op = 2'(o);
        @(posedge clk); #1;
        d2_in_valid = 0;
        e = ref_reduce(128'(v), 2, 1, 2'(o));
        checks++;
        if (d2_out_valid !== 1'b1 || d2_out !== e[0:0] || d2_out_op !== 2'(o)) begin
          errors++;
          $display("FAIL n2 op=%0d a=%0d: valid=%b out=%b op=%b want 1/%b/%0d",
                   o, v, d2_out_valid, d2_out, d2_out_op, e[0], o);
        end
      end
    end
  endtask

  task automatic test_n16();
    logic [9:0] exp_q [$];
    logic [9:0] e;
    int rcvd = 0;
    for (int c = 0; c < 5000 && rcvd < 1000; c++) begin
      @(posedge clk); #1;
      d16_out_ready = ($urandom_range(3) != 0);
      d16_in_valid = 1'($urandom_range(1));
      d16_op = 2'($urandom_range(3));
      d16_a = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(2) == 0) d16_a = ~(128'h1 << $urandom_range(127));
      if ($urandom_range(4) == 0) d16_a = '1;
      #1;
      if (d16_in_valid && d16_in_ready) exp_q.push_back({d16_op, ref_reduce(d16_a, 16, 8, d16_op)});
      if (d16_out_valid && d16_out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL n16 unexpected result %0d: out=%h", rcvd, d16_out);
        end else begin
          e = exp_q.pop_front();
          if ({d16_out_op, d16_out} !== e) begin
            errors++;
            $display("FAIL n16 result %0d: op/out=%b/%h want %b/%h", rcvd, d16_out_op, d16_out,
                     e[9:8], e[7:0]);
          end
        end
        rcvd++;
      end
    end
    d16_in_valid = 0;
    d16_out_ready = 1;
    checks++;
    if (rcvd != 1000) begin
      errors++;
      $display("FAIL n16 count: got %0d want 1000", rcvd);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_idle();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_n2();
    test_n16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
